spi_nor_cmd_sequencer: RTL and testbench
========================================

// Module: spi_nor_cmd_sequencer
// PURPOSE
//  Sequences SPI NOR flash command frames for the APB-to-SPI-NOR controller.
//  Takes one 32-bit read/write request from the APB side and expands it into byte frames:
//   - read:  READ 0x03
//   - write: WREN 0x06, PAGE PROGRAM 0x02, then RDSR 0x05 polling
//  Frames go out over a byte-wide SPI shift engine; the block owns chip select (s_css).
//  Sits between the APB slave register logic and the SPI shifter.
// PARAMETERS
//  CS_GAP    4     min p_clk cycles s_css held high between frames (>=1)
//  POLL_MAX  1024  max RDSR polls per write before timeout error (>=1)
// PORTS
//  p_clk        in   1   system clock; all logic on posedge
//  p_rst        in   1   synchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when req_valid & req_ready
//  req_write    in   1   1 = program word, 0 = read word
//  req_addr     in   24  flash byte address
//  req_wdata    in   32  write data
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  read data, valid with rsp_valid (0 for writes)
//  rsp_err      out  1   poll timeout, valid with rsp_valid
//  sh_tx_valid  out  1   byte to shift
//  sh_tx_data   out  8   byte to shift, MSB-first on the wire
//  sh_tx_ready  in   1   shifter accepts byte when sh_tx_valid & sh_tx_ready
//  sh_rx_valid  in   1   one-cycle pulse: byte exchange complete
//  sh_rx_data   in   8   byte received, valid with sh_rx_valid
//  s_css        out  1   flash chip select, active-low
//  busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (p_rst=1 at posedge): state=IDLE and all counters cleared.
//   Outputs after reset: s_css=1, sh_tx_valid=0, sh_tx_data=0, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, busy=0, req_ready=1.
//   Reset mid-operation aborts immediately: no rsp_valid, s_css high the next cycle.
//   The shifter shares p_rst.
//  req_ready=1 only in IDLE. One request in flight; requests are not queued.
//  States: IDLE, CS_SETUP, XFER, CS_GAP_W, DONE.
//   Frame sub-sequence: WREN, PROG, POLL for writes; READ for reads.
//   IDLE -accept-> CS_SETUP.
//   CS_SETUP (1 cycle): s_css=0 -> XFER.
//   XFER sends the frame bytes. Last sh_rx_valid of the frame -> s_css=1 next cycle -> CS_GAP_W.
//   CS_GAP_W: s_css held high CS_GAP cycles, then CS_SETUP for the next frame, or DONE.
//   DONE: rsp_valid=1 for 1 cycle -> IDLE.
//  Frames (tx byte order):
//   READ  03 A[23:16] A[15:8] A[7:0] 00 00 00 00
//         rx bytes 5..8 -> rsp_rdata[7:0], [15:8], [23:16], [31:24]
//   WREN  06
//   PROG  02 A[23:16] A[15:8] A[7:0] D[7:0] D[15:8] D[23:16] D[31:24]
//   POLL  05 00; second rx byte is status. status[0]=WIP.
//         WIP=1: gap, then repeat POLL. WIP=0: DONE with rsp_err=0.
//  Poll counter increments per POLL frame. If WIP=1 on poll number POLL_MAX -> DONE with rsp_err=1.
//  Byte handshake:
//   - Exactly one byte outstanding: after tx accept, sh_tx_valid=0 until sh_rx_valid.
//   - The next byte is presented the cycle after sh_rx_valid.
//   - sh_tx_valid/sh_tx_data stable while sh_tx_ready=0.
//   - sh_rx_valid with no byte outstanding is ignored.
//  rsp_rdata/rsp_err hold their value until the next DONE.
//  req_valid during DONE is not accepted; accepted in the following IDLE cycle.
//  req_addr/req_wdata are captured at accept; later input changes have no effect.
// TESTING
//  1 Read 0x012345; shifter returns AA,BB,CC,DD on bytes 5-8.
//    -> tx 03 01 23 45 00 00 00 00 in one s_css-low window; rsp_rdata=0xDDCCBBAA, rsp_err=0.
//  2 Write 0x000100, 0x11223344; status 01,01,00.
//    -> tx 06 | 02 00 01 00 44 33 22 11 | 05 00 x3; 5 s_css windows, each gap >= CS_GAP; rsp_err=0.
//  3 POLL_MAX=4, status stuck 0x01 -> exactly 4 POLL frames, then rsp_valid=1, rsp_err=1.
//  4 sh_tx_ready low 10 cycles mid-PROG -> sh_tx_valid=1 and sh_tx_data constant throughout; no byte skipped.
//  5 p_rst pulsed after 3rd PROG byte -> next cycle s_css=1, sh_tx_valid=0, req_ready=1; no rsp_valid.
//  6 req_valid held high across a full read -> exactly one accept per rsp_valid; second accept the cycle after DONE.

Source files
------------

// File: rtl/spi_nor_cmd_sequencer.sv
// SPI NOR command sequencer: expands one APB word request into READ, or WREN/PROG/RDSR-poll
// byte frames for a byte-wide shifter, and owns the active-low chip select.
module spi_nor_cmd_sequencer #(
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic        p_clk,
  input  logic        p_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sh_tx_valid,
  output logic [7:0]  sh_tx_data,
  input  logic        sh_tx_ready,
  input  logic        sh_rx_valid,
  input  logic [7:0]  sh_rx_data,
  output logic        s_css,
  output logic        busy
);

  localparam int GAP_W  = $clog2(CS_GAP + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_SETUP, ST_XFER, ST_CS_GAP_W, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    FR_READ, FR_WREN, FR_PROG, FR_POLL
  } frame_e;

  state_e              state_q, state_d;
  frame_e              frame_q, frame_d;
  logic [2:0]          idx_q, idx_d;
  logic                outst_q, outst_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic                write_q, write_d;
  logic [23:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         acc_q, acc_d;
  logic                fin_q, fin_d;
  logic                fin_err_q, fin_err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                css_q, css_d;

  logic [2:0]          last_idx;
  logic [7:0]          tx_byte;
  logic                tx_fire;
  logic                rx_fire;

  // Byte currently owed to the shifter, selected by frame type and position.
  always_comb begin
    tx_byte  = 8'h00;
    last_idx = 3'd0;
    unique case (frame_q)
      FR_READ: begin
        last_idx = 3'd7;
        unique case (idx_q)
          3'd0:    tx_byte = 8'h03;
          3'd1:    tx_byte = addr_q[23:16];
          3'd2:    tx_byte = addr_q[15:8];
          3'd3:    tx_byte = addr_q[7:0];
          default: tx_byte = 8'h00;
        endcase
      end
      FR_WREN: begin
        last_idx = 3'd0;
        tx_byte  = 8'h06;
      end
      FR_PROG: begin
        last_idx = 3'd7;
        unique case (idx_q)
          3'd0:    tx_byte = 8'h02;
          3'd1:    tx_byte = addr_q[23:16];
          3'd2:    tx_byte = addr_q[15:8];
          3'd3:    tx_byte = addr_q[7:0];
          3'd4:    tx_byte = wdata_q[7:0];
          3'd5:    tx_byte = wdata_q[15:8];
          3'd6:    tx_byte = wdata_q[23:16];
          default: tx_byte = wdata_q[31:24];
        endcase
      end
      default: begin
        last_idx = 3'd1;
        tx_byte  = (idx_q == 3'd0) ? 8'h05 : 8'h00;
      end
    endcase
  end

  assign sh_tx_valid = (state_q == ST_XFER) && !outst_q;
  assign sh_tx_data  = sh_tx_valid ? tx_byte : 8'h00;
  assign tx_fire     = sh_tx_valid && sh_tx_ready;
  // A receive pulse only counts while a byte is actually in flight.
  assign rx_fire     = (state_q == ST_XFER) && outst_q && sh_rx_valid;

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    outst_d   = outst_q;
    gap_d     = gap_q;
    poll_d    = poll_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_d     = acc_q;
    fin_d     = fin_q;
    fin_err_d = fin_err_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          frame_d   = req_write ? FR_WREN : FR_READ;
          idx_d     = 3'd0;
          outst_d   = 1'b0;
          fin_d     = 1'b0;
          fin_err_d = 1'b0;
          state_d   = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: state_d = ST_XFER;
      ST_XFER: begin
        if (tx_fire) outst_d = 1'b1;
        if (rx_fire) begin
          outst_d = 1'b0;
          if (frame_q == FR_READ && idx_q[2]) acc_d[{idx_q[1:0], 3'b000} +: 8] = sh_rx_data;
          if (idx_q == last_idx) begin
            idx_d   = 3'd0;
            gap_d   = '0;
            state_d = ST_CS_GAP_W;
            unique case (frame_q)
              FR_READ: fin_d = 1'b1;
              FR_WREN: frame_d = FR_PROG;
              FR_PROG: begin
                frame_d = FR_POLL;
                poll_d  = '0;
              end
              default: begin
                poll_d = poll_q + 1'b1;
                if (!sh_rx_data[0]) begin
                  fin_d = 1'b1;
                end else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
                  fin_d     = 1'b1;
                  fin_err_d = 1'b1;
                end
              end
            endcase
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_CS_GAP_W: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) begin
          if (fin_q) begin
            state_d = ST_DONE;
            rdata_d = write_q ? 32'h0 : acc_q;
            err_d   = fin_err_q;
          end else begin
            state_d = ST_CS_SETUP;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Chip select is registered from the next state so it is glitch-free and drops with CS_SETUP.
  assign css_d = !(state_d == ST_CS_SETUP || state_d == ST_XFER);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= FR_READ;
      idx_q     <= 3'd0;
      outst_q   <= 1'b0;
      gap_q     <= '0;
      poll_q    <= '0;
      write_q   <= 1'b0;
      addr_q    <= 24'h0;
      wdata_q   <= 32'h0;
      acc_q     <= 32'h0;
      fin_q     <= 1'b0;
      fin_err_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      css_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      outst_q   <= outst_d;
      gap_q     <= gap_d;
      poll_q    <= poll_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      acc_q     <= acc_d;
      fin_q     <= fin_d;
      fin_err_q <= fin_err_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      css_q     <= css_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign s_css     = css_q;

endmodule

// File: tb/tb_spi_nor_cmd_sequencer.sv
// Bench for spi_nor_cmd_sequencer: a shifter/flash model answers frames, and scoreboards
// compare every chip-select window and every response against expectations built at request time.
module tb_spi_nor_cmd_sequencer;

  localparam int CS_GAP   = 4;
  localparam int POLL_MAX = 4;

  logic        p_clk = 1'b0;
  logic        p_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sh_tx_valid;
  logic [7:0]  sh_tx_data;
  logic        sh_tx_ready;
  logic        sh_rx_valid;
  logic [7:0]  sh_rx_data;
  logic        s_css;
  logic        busy;

  spi_nor_cmd_sequencer #(.CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .p_clk(p_clk), .p_rst(p_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sh_tx_valid(sh_tx_valid), .sh_tx_data(sh_tx_data), .sh_tx_ready(sh_tx_ready),
    .sh_rx_valid(sh_rx_valid), .sh_rx_data(sh_rx_data),
    .s_css(s_css), .busy(busy)
  );

  always #5 p_clk = ~p_clk;

  int cyc = 0;
  always @(posedge p_clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Frame bytes are packed with the first byte on the wire in [63:56].
  typedef struct packed { logic [3:0] len; logic [63:0] data; } frame_t;
  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;

  frame_t     exp_frames[$];
  rsp_t       exp_rsp[$];
  logic [7:0] status_q[$];
  logic [7:0] flash_mem[logic [23:0]];
  logic [7:0] ref_mem[logic [23:0]];

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'hFF;
  endfunction

  function automatic logic [7:0] flash_rd(input logic [23:0] a);
    return flash_mem.exists(a) ? flash_mem[a] : 8'hFF;
  endfunction

  // ---------------- reference model: expected frames and response per request
  task automatic push_expect(input bit wr, input logic [23:0] a, input logic [31:0] d,
                             input int k, input bit directed, input bit abort);
    frame_t f;
    if (!wr) begin
      f.len  = 4'd8;
      f.data = {8'h03, a, 32'h0};
      exp_frames.push_back(f);
      exp_rsp.push_back({ref_rd(a + 24'd3), ref_rd(a + 24'd2), ref_rd(a + 24'd1), ref_rd(a), 1'b0});
    end else begin
      int  polls = (k >= POLL_MAX) ? POLL_MAX : k + 1;
      bit  err   = (k >= POLL_MAX);
      f.len  = 4'd1;
      f.data = {8'h06, 56'h0};
      exp_frames.push_back(f);
      f.len  = 4'd8;
      f.data = {8'h02, a, d[7:0], d[15:8], d[23:16], d[31:24]};
      exp_frames.push_back(f);
      for (int i = 0; i < polls; i++) begin
        logic [7:0] r = 8'($urandom);
        f.len  = 4'd2;
        f.data = {8'h05, 56'h0};
        exp_frames.push_back(f);
        if (directed) status_q.push_back((i < k) ? 8'h01 : 8'h00);
        else          status_q.push_back((i < k) ? {r[7:1], 1'b1} : {r[7:1], 1'b0});
      end
      if (!abort)
        for (int i = 0; i < 4; i++) ref_mem[a + 24'(i)] = d[8*i +: 8];
      exp_rsp.push_back({32'h0, err});
    end
  endtask

  // ---------------- shifter + flash environment (drives at posedge + 1)
  logic [7:0] cur[$];
  int         pend = 0;
  logic [7:0] pend_data;
  bit         prev_css = 1'b1;
  int         hi_cnt = 0;
  bit         had_win = 1'b0;
  bit         prog_stall_en = 1'b0;
  bit         stalled = 1'b0;
  int         stall_left = 0;
  int         frame_no = 0;

  task automatic close_frame();
    frame_t got, exp;
    got.len  = (cur.size() > 8) ? 4'hF : 4'(cur.size());
    got.data = 64'h0;
    for (int i = 0; i < cur.size() && i < 8; i++) got.data[63 - 8*i -: 8] = cur[i];
    if (cur.size() == 8 && cur[0] == 8'h02)
      for (int i = 0; i < 4; i++) flash_mem[{cur[1], cur[2], cur[3]} + 24'(i)] = cur[4 + i];
    if (exp_frames.size() == 0) begin
      check(1'b0, $sformatf("unexpected_frame_%0d", frame_no), got.data, 64'h0);
    end else begin
      exp = exp_frames.pop_front();
      check(got == exp, $sformatf("frame_%0d len=%0d/%0d", frame_no, got.len, exp.len), got.data, exp.data);
    end
    frame_no++;
  endtask

  function automatic logic [7:0] resp_byte(input int n);
    logic [7:0] st;
    if (cur[0] == 8'h03 && n >= 4 && n <= 7)
      return flash_rd({cur[1], cur[2], cur[3]} + 24'(n - 4));
    if (cur[0] == 8'h05 && n == 1) begin
      st = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
      return st;
    end
    return 8'($urandom);
  endfunction

  initial begin
    sh_tx_ready = 1'b0;
    sh_rx_valid = 1'b0;
    sh_rx_data  = 8'h00;
    forever begin
      @(posedge p_clk); #1;
      sh_rx_valid = 1'b0;
      if (p_rst) begin
        cur.delete(); exp_frames.delete(); exp_rsp.delete(); status_q.delete();
        pend = 0; stall_left = 0; had_win = 1'b0; hi_cnt = 0; prev_css = 1'b1;
        sh_tx_ready = 1'b0;
        continue;
      end
      if (!s_css && prev_css) begin
        if (had_win) check(hi_cnt >= CS_GAP, "cs_gap", 64'(hi_cnt), 64'(CS_GAP));
        cur.delete();
        stalled = 1'b0;
      end
      if (s_css && !prev_css) begin
        close_frame();
        had_win = 1'b1;
        hi_cnt  = 0;
      end
      if (s_css) hi_cnt++;
      if (!busy) had_win = 1'b0;
      prev_css = s_css;
      if (sh_tx_valid && s_css) check(1'b0, "tx_while_css_high", 64'(s_css), 64'h0);

      if (pend > 0) begin
        if (sh_tx_valid) check(1'b0, "one_outstanding", 64'(sh_tx_valid), 64'h0);
        pend--;
        if (pend == 0) begin
          sh_rx_valid = 1'b1;
          sh_rx_data  = pend_data;
        end
        sh_tx_ready = 1'($urandom_range(0, 1));
      end else begin
        if (prog_stall_en && !stalled && cur.size() == 4 && cur[0] == 8'h02) begin
          stall_left = 10;
          stalled    = 1'b1;
        end
        if (stall_left > 0) begin
          sh_tx_ready = 1'b0;
          stall_left--;
        end else begin
          sh_tx_ready = ($urandom_range(0, 3) != 0);
        end
        if (sh_tx_valid && sh_tx_ready) begin
          cur.push_back(sh_tx_data);
          pend_data = resp_byte(cur.size() - 1);
          pend      = $urandom_range(1, 3);
        end else if ($urandom_range(0, 7) == 0) begin
          sh_rx_valid = 1'b1;
          sh_rx_data  = 8'($urandom);
        end
      end
    end
  end

  // ---------------- monitor: response scoreboard and tx stability (samples at negedge)
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data;
  int          last_rsp_cyc = -1;
  int          rsp_cnt = 0;
  int          stall_checks = 0;
  logic [31:0] last_rdata = 32'h0;

  initial begin
    forever begin
      @(negedge p_clk);
      if (p_rst) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        stall_checks++;
        check(sh_tx_valid && sh_tx_data == prev_data, "tx_hold", {sh_tx_valid, sh_tx_data}, {1'b1, prev_data});
      end
      prev_hold = sh_tx_valid && !sh_tx_ready;
      prev_data = sh_tx_data;
      if (rsp_valid) begin
        rsp_t e;
        last_rsp_cyc = cyc;
        rsp_cnt++;
        if (exp_rsp.size() == 0) begin
          check(1'b0, "unexpected_rsp", {rsp_rdata, rsp_err}, 64'h0);
        end else begin
          e = exp_rsp.pop_front();
          last_rdata = e.rdata;
          check({rsp_rdata, rsp_err} == {e.rdata, e.err}, "rsp", {rsp_rdata, rsp_err}, {e.rdata, e.err});
        end
      end
    end
  end

  // ---------------- stimulus (drives at posedge + 2)
  task automatic issue(input bit wr, input logic [23:0] a, input logic [31:0] d,
                       input int k, input bit directed, input bit abort);
    int t = 0;
    @(posedge p_clk); #2;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    forever begin
      @(negedge p_clk);
      if (req_ready) break;
      t++;
      if (t > 4000) begin
        check(1'b0, "accept_timeout", 64'(t), 64'h0);
        req_valid = 1'b0;
        return;
      end
    end
    push_expect(wr, a, d, k, directed, abort);
    @(posedge p_clk); #2;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 24'($urandom); req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge p_clk);
      if (exp_rsp.size() == 0 && !busy) break;
      t++;
      if (t > 8000) begin
        check(1'b0, "idle_timeout", 64'(exp_rsp.size()), 64'h0);
        break;
      end
    end
  endtask

  initial begin
    int acc_cyc[2];
    int acc_rsp[2];
    int n;
    int t;
    p_rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 24'h0; req_wdata = 32'h0;
    repeat (3) @(posedge p_clk);
    #2 p_rst = 1'b0;
    @(negedge p_clk);
    check(s_css == 1'b1,       "rst_css",      64'(s_css), 64'h1);
    check(sh_tx_valid == 1'b0, "rst_tx_valid", 64'(sh_tx_valid), 64'h0);
    check(sh_tx_data == 8'h00, "rst_tx_data",  64'(sh_tx_data), 64'h0);
    check(rsp_valid == 1'b0,   "rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check(rsp_rdata == 32'h0,  "rst_rdata",    64'(rsp_rdata), 64'h0);
    check(rsp_err == 1'b0,     "rst_err",      64'(rsp_err), 64'h0);
    check(busy == 1'b0,        "rst_busy",     64'(busy), 64'h0);
    check(req_ready == 1'b1,   "rst_ready",    64'(req_ready), 64'h1);

    // Directed read of preloaded data.
    for (int i = 0; i < 4; i++) begin
      flash_mem[24'h012345 + 24'(i)] = 8'hAA + 8'(17 * i);
      ref_mem[24'h012345 + 24'(i)]   = 8'hAA + 8'(17 * i);
    end
    issue(1'b0, 24'h012345, 32'h0, 0, 1'b1, 1'b0);
    wait_idle();
    repeat (5) @(negedge p_clk);
    check(rsp_rdata == 32'hDDCCBBAA, "rdata_hold", 64'(rsp_rdata), 64'hDDCCBBAA);

    // Directed write with two busy polls, then a stuck-busy write that times out.
    issue(1'b1, 24'h000100, 32'h11223344, 2, 1'b1, 1'b0);
    wait_idle();
    issue(1'b1, 24'h000200, 32'hCAFEF00D, 10, 1'b1, 1'b0);
    wait_idle();
    check(rsp_rdata == 32'h0 && rsp_err == 1'b1, "timeout_hold", {rsp_rdata, rsp_err}, 64'h1);

    // Ten-cycle shifter stall in the middle of PROG.
    prog_stall_en = 1'b1;
    n = stall_checks;
    issue(1'b1, 24'h000104, 32'hA5A55A5A, 1, 1'b0, 1'b0);
    wait_idle();
    prog_stall_en = 1'b0;
    check(stall_checks - n >= 10, "stall_seen", 64'(stall_checks - n), 64'd10);
    issue(1'b0, 24'h000104, 32'h0, 0, 1'b0, 1'b0);
    wait_idle();

    // Reset after the third PROG byte aborts the write.
    issue(1'b1, 24'h000300, 32'h01020304, 0, 1'b0, 1'b1);
    t = 0;
    forever begin
      @(posedge p_clk); #2;
      if (cur.size() == 3 && cur[0] == 8'h02) break;
      t++;
      if (t > 4000) begin
        check(1'b0, "prog_wait_timeout", 64'(t), 64'h0);
        break;
      end
    end
    n = rsp_cnt;
    p_rst = 1'b1;
    @(posedge p_clk); #2;
    p_rst = 1'b0;
    @(negedge p_clk);
    check(s_css == 1'b1,       "abort_css",      64'(s_css), 64'h1);
    check(sh_tx_valid == 1'b0, "abort_tx_valid", 64'(sh_tx_valid), 64'h0);
    check(req_ready == 1'b1,   "abort_ready",    64'(req_ready), 64'h1);
    repeat (30) @(negedge p_clk);
    check(rsp_cnt == n, "abort_no_rsp", 64'(rsp_cnt), 64'(n));

    // req_valid held high across a full read: the second accept follows DONE by one cycle.
    @(posedge p_clk); #2;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h012345;
    n = 0; t = 0;
    while (n < 2 && t < 4000) begin
      @(negedge p_clk);
      t++;
      if (req_ready) begin
        push_expect(1'b0, 24'h012345, 32'h0, 0, 1'b0, 1'b0);
        acc_cyc[n] = cyc;
        acc_rsp[n] = rsp_cnt;
        n++;
      end
    end
    @(posedge p_clk); #2;
    req_valid = 1'b0;
    check(n == 2, "held_accepts", 64'(n), 64'd2);
    if (n == 2) begin
      check(acc_rsp[1] - acc_rsp[0] == 1, "held_one_rsp_between", 64'(acc_rsp[1] - acc_rsp[0]), 64'd1);
      check(acc_cyc[1] == last_rsp_cyc + 1, "held_accept_after_done", 64'(acc_cyc[1]), 64'(last_rsp_cyc + 1));
    end
    wait_idle();

    // Randomized mix of reads and writes over a small address window.
    for (int i = 0; i < 40; i++) begin
      bit          wr = 1'($urandom_range(0, 1));
      logic [23:0] a  = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h000100 + 24'($urandom_range(0, 15));
      issue(wr, a, $urandom, $urandom_range(0, 4), 1'b0, 1'b0);
    end
    wait_idle();
    repeat (10) @(negedge p_clk);
    check(exp_frames.size() == 0, "frames_left", 64'(exp_frames.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
